// File: rtl/prom16_loader.sv
// Streams DEPTH program bytes into the SAP program PROM over valid/ready and strobes each write.
// Define PROM16_LOADER_VERIFY_EN to add an XOR read-back verify pass after the last write.
module prom16_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_low_load,
  output logic              mem_low_o_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef PROM16_LOADER_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd4;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] checksum;

`ifdef PROM16_LOADER_VERIFY_EN
  logic [DATA_W-1:0] rd_sum;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_low_o_en = 1'b1;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= S_IDLE;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_low_load <= 1'b1;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      checksum     <= '0;
`ifdef PROM16_LOADER_VERIFY_EN
      mem_low_o_en <= 1'b1;
      err          <= 1'b0;
      rd_sum       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            mem_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            checksum <= '0;
            in_ready <= 1'b1;
`ifdef PROM16_LOADER_VERIFY_EN
            err      <= 1'b0;
`endif
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            mem_data     <= in_data;
            checksum     <= checksum ^ in_data;
            in_ready     <= 1'b0;
            mem_low_load <= 1'b0;
            state        <= S_WRITE;
          end
        end

        S_WRITE: begin
          mem_low_load <= 1'b1;
          if (mem_addr == LAST_ADDR) begin
`ifdef PROM16_LOADER_VERIFY_EN
            state        <= S_VERIFY;
            mem_addr     <= '0;
            rd_sum       <= '0;
            mem_low_o_en <= 1'b0;
`else
            state        <= S_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
`endif
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end

`ifdef PROM16_LOADER_VERIFY_EN
        // Last read word is folded in combinationally so the verdict lands on the same edge.
        S_VERIFY: begin
          if (mem_addr == LAST_ADDR) begin
            err          <= ((rd_sum ^ mem_rdata) != checksum);
            mem_low_o_en <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= S_DONE;
          end else begin
            rd_sum   <= rd_sum ^ mem_rdata;
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prom16_loader.sv
// Directed bench for prom16_loader with a behavioural PROM; follows PROM16_LOADER_VERIFY_EN if defined.
module tb_prom16_loader;

  logic       clk = 1'b0;
  logic       clr, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_low_load, mem_low_o_en;
  logic [7:0] mem_rdata;
  logic       busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int n_strobe = 0;
  int s_snap;
  logic oe_low_seen = 1'b0;
  logic bad5 = 1'b0;
  logic [7:0] prom [16];

`ifdef PROM16_LOADER_VERIFY_EN
  localparam logic VER_ON = 1'b1;
`else
  localparam logic VER_ON = 1'b0;
`endif

  prom16_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_low_load(mem_low_load), .mem_low_o_en(mem_low_o_en), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // PROM model: write captured at the edge that closes a strobe-low cycle.
  always @(posedge clk) if (mem_low_load === 1'b0) prom[mem_addr] <= mem_data;
  assign mem_rdata = (bad5 && mem_addr == 4'd5) ? 8'h55 : prom[mem_addr];

  always @(negedge clk) begin
    if (mem_low_load === 1'b0) n_strobe++;
    if (mem_low_o_en === 1'b0) oe_low_seen = 1'b1;
    if (cyc > 0) begin
      n_checks++;
      assert (!(mem_low_load === 1'b0 && mem_low_o_en === 1'b0)) else begin
        n_fail++;
        $error("FAIL strobe_overlap: got load=%b oe=%b required not both 0", mem_low_load, mem_low_o_en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    chk("start_err", 32'(err), 0);
    chk("start_ready", 32'(in_ready), 1);
    chk("start_addr", 32'(mem_addr), 0);
  endtask

  task automatic load_word(input int i, input logic [7:0] d, input logic stall, input logic poke);
    if (stall) begin
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk("stall_ready", 32'(in_ready), 1);
        chk("stall_load", 32'(mem_low_load), 1);
        chk("stall_addr", 32'(mem_addr), 32'(i));
        tick();
      end
    end
    in_data  = d;
    in_valid = 1'b1;
    start    = poke;
    chk("load_ready", 32'(in_ready), 1);
    chk("load_strobe_off", 32'(mem_low_load), 1);
    chk("load_addr", 32'(mem_addr), 32'(i));
    chk("load_busy", 32'(busy), 1);
    tick();
    chk("wr_strobe", 32'(mem_low_load), 0);
    chk("wr_addr", 32'(mem_addr), 32'(i));
    chk("wr_data", 32'(mem_data), 32'(d));
    chk("wr_ready", 32'(in_ready), 0);
    chk("wr_done", 32'(done), 0);
    in_data = ~d;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_session(input logic exp_err, input logic timed);
    if (VER_ON) begin
      for (int k = 0; k < 16; k++) begin
        chk("ver_addr", 32'(mem_addr), 32'(k));
        chk("ver_oe", 32'(mem_low_o_en), 0);
        chk("ver_done", 32'(done), 0);
        tick();
      end
    end
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_addr", 32'(mem_addr), 15);
    chk("end_err", 32'(err), 32'(exp_err));
    chk("end_oe", 32'(mem_low_o_en), 1);
    if (timed) chk("done_edge", 32'(cyc - t0), VER_ON ? 48 : 32);
  endtask

  initial begin
    clr = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_load", 32'(mem_low_load), 1);
    chk("rst_oe", 32'(mem_low_o_en), 1);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_err", 32'(err), 0);
    clr = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Session A: back-to-back load of 0..15, timed
    begin_session();
    for (int i = 0; i < 16; i++) load_word(i, 8'(i), 1'b0, 1'b0);
    finish_session(1'b0, 1'b1);
    chk("strobes_a", 32'(n_strobe), 16);
    for (int i = 0; i < 16; i++) chk("prom_a", 32'(prom[i]), 32'(i));
    // No 17th byte
    in_valid = 1'b1; in_data = 8'h99;
    tick(); tick(); tick();
    chk("no17_ready", 32'(in_ready), 0);
    chk("no17_strobes", 32'(n_strobe), 16);
    chk("no17_done", 32'(done), 1);

    // Session B: restart from DONE, stall before word 4, start poked during word 7
    begin_session();
    for (int i = 0; i < 16; i++) load_word(i, 8'hF0 + 8'(i), i == 4, i == 7);
    finish_session(1'b0, 1'b0);
    chk("strobes_b", 32'(n_strobe), 32);
    for (int i = 0; i < 16; i++) chk("prom_b", 32'(prom[i]), 32'(8'hF0 + 8'(i)));

    // Session C: reset during WRITE of word 9
    begin_session();
    for (int i = 0; i < 9; i++) load_word(i, 8'hA0 + 8'(i), 1'b0, 1'b0);
    in_data = 8'hA9; in_valid = 1'b1;
    tick();
    chk("abort_wr", 32'(mem_low_load), 0);
    chk("abort_wr_addr", 32'(mem_addr), 9);
    clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("abort_load", 32'(mem_low_load), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(in_ready), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    s_snap = n_strobe;
    tick(); tick(); tick();
    chk("abort_no_strobe", 32'(n_strobe), 32'(s_snap));
    chk("abort_keep9", 32'(prom[9]), 8'hA9);
    chk("abort_keep10", 32'(prom[10]), 8'hFA);

    // Session D: new start from IDLE, healthy read-back
    begin_session();
    for (int i = 0; i < 16; i++) load_word(i, 8'(i), 1'b0, 1'b0);
    finish_session(1'b0, 1'b1);

    // Session E: PROM returns 0x55 at address 5
    bad5 = 1'b1;
    begin_session();
    for (int i = 0; i < 16; i++) load_word(i, 8'(i), 1'b0, 1'b0);
    finish_session(VER_ON, 1'b1);
    tick();
    chk("err_hold", 32'(err), 32'(VER_ON));
    bad5 = 1'b0;
    begin_session();
    chk("oe_seen", 32'(oe_low_seen), 32'(VER_ON));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
